// File: rtl/sysid_check_master.sv
// Avalon-MM read master that checks the system-ID and build-timestamp words.
// Latency: 3 + 2*READ_LATENCY + stall cycles per attempt; every retry adds one more attempt.
// Backpressure: avm_read/avm_address stay stable while avm_waitrequest is high; a stall of TIMEOUT_CYCLES edges aborts the check.
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1520443765,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          MAX_RETRIES        = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value
);

  localparam logic [1:0] LAT   = 2'(READ_LATENCY);
  localparam logic [8:0] TMO   = 9'(TIMEOUT_CYCLES);
  localparam logic [2:0] MAX_R = 3'(MAX_RETRIES);

  localparam logic [1:0] FC_PASS    = 2'b00;
  localparam logic [1:0] FC_ID      = 2'b01;
  localparam logic [1:0] FC_TS      = 2'b10;
  localparam logic [1:0] FC_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_ID  = 3'd1,
    LAT_ID = 3'd2,
    RD_TS  = 3'd3,
    LAT_TS = 3'd4,
    CHECK  = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  tmo_cnt, tmo_cnt_nxt;
  logic [1:0]  lat_cnt, lat_cnt_nxt;
  logic [2:0]  retry_cnt, retry_cnt_nxt;

  logic        address_nxt, read_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [1:0]  fail_code_nxt;
  logic [31:0] id_value_nxt, timestamp_value_nxt;

  // Shared decode used by both the next-state and the output logic.
  logic accepted, stalled, tmo_hit, lat_last, id_bad, ts_bad, retry_ok, in_rd;

  assign in_rd    = (state == RD_ID) || (state == RD_TS);
  assign accepted = in_rd && avm_read && !avm_waitrequest;
  assign stalled  = in_rd && avm_read && avm_waitrequest;
  assign tmo_hit  = stalled && (({1'b0, tmo_cnt} + 9'd1) == TMO);
  assign lat_last = (lat_cnt == LAT);
  assign id_bad   = (id_value != EXPECTED_ID);
  assign ts_bad   = (timestamp_value != EXPECTED_TIMESTAMP);
  assign retry_ok = (retry_cnt < MAX_R);

  // State and registered outputs; reset returns everything to idle values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      tmo_cnt         <= '0;
      lat_cnt         <= '0;
      retry_cnt       <= '0;
      avm_address     <= 1'b0;
      avm_read        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail_code       <= FC_PASS;
      id_value        <= '0;
      timestamp_value <= '0;
    end else begin
      state           <= state_nxt;
      tmo_cnt         <= tmo_cnt_nxt;
      lat_cnt         <= lat_cnt_nxt;
      retry_cnt       <= retry_cnt_nxt;
      avm_address     <= address_nxt;
      avm_read        <= read_nxt;
      busy            <= busy_nxt;
      done            <= done_nxt;
      pass            <= pass_nxt;
      fail_code       <= fail_code_nxt;
      id_value        <= id_value_nxt;
      timestamp_value <= timestamp_value_nxt;
    end
  end

  // Next-state: read ID, read timestamp, compare, loop back on a retryable mismatch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = RD_ID;
      RD_ID: begin
        if (tmo_hit)       state_nxt = IDLE;
        else if (accepted) state_nxt = (LAT == 2'd0) ? RD_TS : LAT_ID;
      end
      LAT_ID: if (lat_last) state_nxt = RD_TS;
      RD_TS: begin
        if (tmo_hit)       state_nxt = IDLE;
        else if (accepted) state_nxt = (LAT == 2'd0) ? CHECK : LAT_TS;
      end
      LAT_TS: if (lat_last) state_nxt = CHECK;
      CHECK:  state_nxt = ((id_bad || ts_bad) && retry_ok) ? RD_ID : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of outputs and counters, derived from the current state and the chosen transition.
  always_comb begin
    address_nxt         = avm_address;
    done_nxt            = done;
    pass_nxt            = pass;
    fail_code_nxt       = fail_code;
    id_value_nxt        = id_value;
    timestamp_value_nxt = timestamp_value;
    retry_cnt_nxt       = retry_cnt;
    // The stall counter only survives while the same read keeps stalling.
    tmo_cnt_nxt         = (stalled && !tmo_hit) ? tmo_cnt + 8'd1 : 8'd0;
    // Latency counter sits at 1 until a LAT state starts counting from the acceptance edge.
    lat_cnt_nxt         = ((state == LAT_ID || state == LAT_TS) && !lat_last) ? lat_cnt + 2'd1 : 2'd1;

    read_nxt = (state_nxt == RD_ID) || (state_nxt == RD_TS);
    busy_nxt = (state_nxt != IDLE);
    if (state_nxt == RD_ID) address_nxt = 1'b0;
    if (state_nxt == RD_TS) address_nxt = 1'b1;

    case (state)
      IDLE: begin
        if (start) begin
          done_nxt      = 1'b0;
          pass_nxt      = 1'b0;
          fail_code_nxt = FC_PASS;
          retry_cnt_nxt = '0;
        end
      end
      RD_ID, RD_TS: begin
        if (tmo_hit) begin
          done_nxt      = 1'b1;
          pass_nxt      = 1'b0;
          fail_code_nxt = FC_TIMEOUT;
        end else if (accepted && LAT == 2'd0) begin
          if (state == RD_ID) id_value_nxt        = avm_readdata;
          else                timestamp_value_nxt = avm_readdata;
        end
      end
      LAT_ID: if (lat_last) id_value_nxt        = avm_readdata;
      LAT_TS: if (lat_last) timestamp_value_nxt = avm_readdata;
      CHECK: begin
        if (!id_bad && !ts_bad) begin
          done_nxt      = 1'b1;
          pass_nxt      = 1'b1;
          fail_code_nxt = FC_PASS;
        end else if (retry_ok) begin
          retry_cnt_nxt = retry_cnt + 3'd1;
        end else begin
          done_nxt      = 1'b1;
          pass_nxt      = 1'b0;
          fail_code_nxt = id_bad ? FC_ID : FC_TS;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sysid_check_master.sv
// Directed bench for sysid_check_master: zero-latency instance with a stalling slave
// and a READ_LATENCY=2 / MAX_RETRIES=0 instance with a pipelined slave.
module tb_sysid_check_master;

  localparam logic [31:0] TS_OK = 32'h5AA02175;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // ---------------- instance 0: default parameters ----------------
  logic        start0 = 1'b0;
  logic        adr0, read0, wait0, busy0, done0, pass0;
  logic [1:0]  fc0;
  logic [31:0] rdata0, idv0, tsv0;

  int   id_mode    = 0;   // 0 good, 1 ID always 1, 2 ID wrong on first attempt only
  int   stall_mode = 0;   // 0 none, 1 five stall cycles per read, 2 stuck high
  int   id_acc     = 0;
  int   id_base    = 0;
  int   scnt       = 0;
  int   reads0     = 0;

  assign wait0  = (stall_mode == 2) || (stall_mode == 1 && scnt < 5);
  assign rdata0 = adr0 ? TS_OK :
                  ((id_mode == 1) || (id_mode == 2 && id_acc == id_base)) ? 32'h1 : 32'h0;

  always @(posedge clock) begin
    if (reset) scnt <= 0;
    else if (read0 && !wait0) scnt <= 0;
    else if (read0 && wait0) scnt <= scnt + 1;
    if (!reset && read0 && !wait0) begin
      reads0 <= reads0 + 1;
      if (!adr0) id_acc <= id_acc + 1;
    end
  end

  sysid_check_master dut0 (
    .clock(clock), .reset(reset), .start(start0),
    .avm_address(adr0), .avm_read(read0), .avm_waitrequest(wait0), .avm_readdata(rdata0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_code(fc0),
    .id_value(idv0), .timestamp_value(tsv0)
  );

  // ---------------- instance 1: READ_LATENCY=2, MAX_RETRIES=0 ----------------
  logic        start1 = 1'b0;
  logic        adr1, read1, busy1, done1, pass1;
  logic        wait1 = 1'b0;
  logic [1:0]  fc1;
  logic [31:0] rdata1, idv1, tsv1;
  logic        ts_bad = 1'b0;
  logic        p1_v, p1_a, p2_v, p2_a;

  // Slave pipeline: data for a read accepted on edge a is presented only between edges a+1 and a+2.
  always @(posedge clock) begin
    if (reset) begin
      p1_v <= 1'b0; p1_a <= 1'b0; p2_v <= 1'b0; p2_a <= 1'b0;
    end else begin
      p1_v <= read1 && !wait1;
      p1_a <= adr1;
      p2_v <= p1_v;
      p2_a <= p1_a;
    end
  end
  assign rdata1 = !p2_v ? 32'hDEADBEEF : (p2_a ? (ts_bad ? 32'h5AA02176 : TS_OK) : 32'h0);

  sysid_check_master #(.READ_LATENCY(2), .MAX_RETRIES(0)) dut1 (
    .clock(clock), .reset(reset), .start(start1),
    .avm_address(adr1), .avm_read(read1), .avm_waitrequest(wait1), .avm_readdata(rdata1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_code(fc1),
    .id_value(idv1), .timestamp_value(tsv1)
  );

  // Pulse start on one instance; returns at the negedge after edge k.
  task automatic pulse_start(input int which);
    @(negedge clock);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Counts edges after edge k until done is seen (bounded); result is the edge index.
  task automatic wait_done(input int which, input int limit, output int cyc);
    cyc = 0;
    while (((which == 0) ? !done0 : !done1) && cyc < limit) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    tests++; if (read0 !== 1'b0)  begin fails++; $display("FAIL reset_read: got %b expected 0", read0); end
    tests++; if (adr0 !== 1'b0)   begin fails++; $display("FAIL reset_addr: got %b expected 0", adr0); end
    tests++; if ({busy0, done0, pass0} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {busy0, done0, pass0}); end
    tests++; if (fc0 !== 2'b00)   begin fails++; $display("FAIL reset_fc: got %b expected 00", fc0); end
    tests++; if ({idv0, tsv0} !== 64'h0) begin fails++; $display("FAIL reset_values: got %h expected 0", {idv0, tsv0}); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_pass;
    int cyc;
    id_mode = 0; stall_mode = 0;
    pulse_start(0);
    tests++; if ({read0, adr0, busy0, done0} !== 4'b1010) begin fails++; $display("FAIL pass_issue: got %b expected 1010", {read0, adr0, busy0, done0}); end
    wait_done(0, 50, cyc);
    tests++; if (cyc !== 3)       begin fails++; $display("FAIL pass_latency: got %0d expected 3", cyc); end
    tests++; if ({pass0, fc0} !== 3'b100) begin fails++; $display("FAIL pass_result: got %b expected 100", {pass0, fc0}); end
    tests++; if (tsv0 !== TS_OK)  begin fails++; $display("FAIL pass_ts: got %h expected %h", tsv0, TS_OK); end
    tests++; if ({read0, busy0} !== 2'b00) begin fails++; $display("FAIL pass_idle: got %b expected 00", {read0, busy0}); end
    repeat (3) @(negedge clock);
    tests++; if ({done0, pass0} !== 2'b11) begin fails++; $display("FAIL pass_hold: got %b expected 11", {done0, pass0}); end
  endtask

  task automatic test_retry_exhaust;
    int cyc;
    id_mode = 1; stall_mode = 0;
    pulse_start(0);
    tests++; if (done0 !== 1'b0) begin fails++; $display("FAIL retry_done_cleared: got %b expected 0", done0); end
    wait_done(0, 60, cyc);
    tests++; if (cyc !== 12)     begin fails++; $display("FAIL retry_latency: got %0d expected 12", cyc); end
    tests++; if ({pass0, fc0} !== 3'b001) begin fails++; $display("FAIL retry_result: got %b expected 001", {pass0, fc0}); end
    tests++; if (idv0 !== 32'h1) begin fails++; $display("FAIL retry_id: got %h expected 1", idv0); end
  endtask

  task automatic test_retry_once;
    int cyc;
    id_mode = 2; stall_mode = 0; id_base = id_acc;
    pulse_start(0);
    wait_done(0, 60, cyc);
    tests++; if (cyc !== 6)      begin fails++; $display("FAIL retry1_latency: got %0d expected 6", cyc); end
    tests++; if ({pass0, fc0} !== 3'b100) begin fails++; $display("FAIL retry1_result: got %b expected 100", {pass0, fc0}); end
    id_mode = 0;
  endtask

  task automatic test_stall;
    int cyc, viol;
    logic pr, pw, pa;
    id_mode = 0; stall_mode = 1; viol = 0;
    pulse_start(0);
    cyc = 0; pr = read0; pw = wait0; pa = adr0;
    while (!done0 && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (pr && pw && !(read0 && adr0 == pa)) viol++;
      pr = read0; pw = wait0; pa = adr0;
    end
    tests++; if (viol !== 0)  begin fails++; $display("FAIL stall_stable: got %0d changes expected 0", viol); end
    tests++; if (cyc !== 13)  begin fails++; $display("FAIL stall_latency: got %0d expected 13", cyc); end
    tests++; if (pass0 !== 1'b1) begin fails++; $display("FAIL stall_pass: got %b expected 1", pass0); end
    stall_mode = 0;
  endtask

  task automatic test_timeout;
    int cyc, r0;
    stall_mode = 2;
    pulse_start(0);
    wait_done(0, 300, cyc);
    tests++; if (cyc !== 255) begin fails++; $display("FAIL tmo_latency: got %0d expected 255", cyc); end
    tests++; if ({read0, busy0, pass0, fc0} !== 5'b00011) begin fails++; $display("FAIL tmo_result: got %b expected 00011", {read0, busy0, pass0, fc0}); end
    r0 = 0;
    repeat (20) begin @(negedge clock); if (read0) r0++; end
    tests++; if (r0 !== 0) begin fails++; $display("FAIL tmo_no_reads: got %0d expected 0", r0); end
    stall_mode = 0;
  endtask

  task automatic test_latency;
    int cyc;
    ts_bad = 1'b0;
    pulse_start(1);
    wait_done(1, 60, cyc);
    tests++; if (cyc !== 7) begin fails++; $display("FAIL lat_latency: got %0d expected 7", cyc); end
    tests++; if ({pass1, fc1} !== 3'b100) begin fails++; $display("FAIL lat_result: got %b expected 100", {pass1, fc1}); end
    tests++; if (tsv1 !== TS_OK) begin fails++; $display("FAIL lat_ts: got %h expected %h", tsv1, TS_OK); end
    ts_bad = 1'b1;
    pulse_start(1);
    wait_done(1, 60, cyc);
    tests++; if (cyc !== 7) begin fails++; $display("FAIL lat_bad_latency: got %0d expected 7", cyc); end
    tests++; if ({pass1, fc1} !== 3'b010) begin fails++; $display("FAIL lat_bad_result: got %b expected 010", {pass1, fc1}); end
    ts_bad = 1'b0;
  endtask

  task automatic test_reset_mid;
    int cyc;
    pulse_start(1);
    repeat (4) @(negedge clock);          // after edge k+4: LAT_TS
    tests++; if ({busy1, read1, adr1} !== 3'b101) begin fails++; $display("FAIL mid_in_lat: got %b expected 101", {busy1, read1, adr1}); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    tests++; if ({read1, busy1, done1, pass1, fc1} !== 6'b0) begin fails++; $display("FAIL mid_reset_flags: got %b expected 000000", {read1, busy1, done1, pass1, fc1}); end
    tests++; if ({idv1, tsv1} !== 64'h0) begin fails++; $display("FAIL mid_reset_values: got %h expected 0", {idv1, tsv1}); end
    repeat (4) @(negedge clock);
    tests++; if ({busy1, done1, tsv1} !== 34'h0) begin fails++; $display("FAIL mid_quiet: got %h expected 0", {busy1, done1, tsv1}); end
    pulse_start(1);
    @(negedge clock);
    start1 = 1'b1;                          // sampled on edge k+2 while busy
    @(negedge clock);
    start1 = 1'b0;
    wait_done(1, 60, cyc);
    tests++; if (cyc + 2 !== 7) begin fails++; $display("FAIL mid_latency: got %0d expected 7", cyc + 2); end
    tests++; if ({pass1, fc1} !== 3'b100) begin fails++; $display("FAIL mid_result: got %b expected 100", {pass1, fc1}); end
    repeat (3) @(negedge clock);
    tests++; if ({busy1, done1} !== 2'b01) begin fails++; $display("FAIL mid_no_restart: got %b expected 01", {busy1, done1}); end
  endtask

  initial begin
    test_reset;
    test_pass;
    test_retry_exhaust;
    test_retry_once;
    test_stall;
    test_timeout;
    test_latency;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sysid_check_master.md
# sysid_check_master

Avalon-MM read master that sits directly upstream of the system-ID slave. On a start pulse it reads the ID word (address 0) and the build-timestamp word (address 1), compares both against expected constants, retries on mismatch, and reports pass/fail to the boot/status logic. This lets hardware refuse to proceed when the loaded SOC image does not match the software build.

## Interface
- EXPECTED_ID, 32'd0, expected word at address 0
- EXPECTED_TIMESTAMP, 32'd1520443765 (0x5AA02175), expected word at address 1
- READ_LATENCY, 0, cycles from read acceptance to valid avm_readdata (0..3)
- TIMEOUT_CYCLES, 255, max waitrequest-stalled cycles per read (1..255, 8-bit counter)
- MAX_RETRIES, 3, extra full attempts after a compare mismatch (0..7)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin check; sampled only in IDLE
- avm_address  out  1  0 = ID, 1 = timestamp
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall; read accepted on edge where avm_read=1 and avm_waitrequest=0
- avm_readdata  in  32  slave read data
- busy  out  1  high from start acceptance until done
- done  out  1  level; high when check finished, cleared by next accepted start
- pass  out  1  valid while done; 1 = both words matched
- fail_code  out  2  00 pass, 01 ID mismatch, 10 timestamp mismatch, 11 timeout
- id_value  out  32  last captured ID word
- timestamp_value  out  32  last captured timestamp word

## Operation
- All outputs registered. Reset values: avm_read 0, avm_address 0, busy 0, done 0, pass 0, fail_code 00, id_value 0, timestamp_value 0; FSM IDLE, retry and timeout counters 0.
- States: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK.
- IDLE: start=1 -> RD_ID; avm_read=1, avm_address=0, busy=1, done=0, pass=0, fail_code=00, timeout counter cleared. start=0 -> stay.
- RD_x: hold avm_read/avm_address stable until accepted. On acceptance: READ_LATENCY=0 -> capture avm_readdata same edge and advance (RD_ID->RD_TS with address=1, read held 1; RD_TS->CHECK with read=0); READ_LATENCY>0 -> read=0, go LAT_x.
- LAT_x: count READ_LATENCY edges from acceptance; capture on the READ_LATENCY-th edge, then advance as above.
- Timeout: counter increments each edge in RD_x with waitrequest=1; on reaching TIMEOUT_CYCLES -> read=0, done=1, busy=0, pass=0, fail_code=11, IDLE. No retry on timeout. Counter cleared on each new read.
- CHECK (one edge): ID mismatch has priority over timestamp mismatch. Match -> done=1, pass=1, fail_code=00, busy=0, IDLE. Mismatch with retries used < MAX_RETRIES -> retries+1, RD_ID (read=1, address=0), done stays 0. Mismatch with retries exhausted -> done=1, pass=0, fail_code 01/10, IDLE. Retry counter cleared on start acceptance.
- start while busy ignored. start in the same edge that done rises is ignored (FSM not yet IDLE).
- reset at any cycle, including with a read outstanding or in LAT_x: all state to reset values next edge; late readdata ignored.

## Timing
- Edge k = edge sampling start=1 in IDLE. avm_read high after edge k.
- Zero-wait, READ_LATENCY=0: ID captured edge k+1, timestamp edge k+2, done/pass high after edge k+3 (3 cycles).
- General per attempt: 3 + 2*READ_LATENCY + total stall cycles. Each retry adds one full attempt; CHECK edge issues next RD_ID directly.
- done/pass/fail_code remain stable until next accepted start or reset.

## Test plan
- Default params, waitrequest=0, slave returns 0 / 0x5AA02175 -> done after edge k+3, pass=1, fail_code=00, timestamp_value=0x5AA02175, avm_read low from k+3.
- Slave returns ID 0x00000001 always, MAX_RETRIES=3 -> 4 attempts, done after edge k+12, pass=0, fail_code=01, id_value=1; variant returning wrong ID on attempt 1 only -> done after k+6, pass=1.
- waitrequest high 5 cycles per read -> address/read stable during stall, done after k+13, pass=1.
- waitrequest stuck high, TIMEOUT_CYCLES=255 -> after 255 stalled edges avm_read=0, done=1, fail_code=11, no further reads.
- READ_LATENCY=2, slave data valid 2 cycles after acceptance, correct words -> done after k+7, pass=1; wrong timestamp with MAX_RETRIES=0 -> fail_code=10.
- Reset pulsed while in LAT_TS, then start pulsed during busy in a later run -> after reset edge all outputs at reset values; mid-run start has no effect, run completes normally.
